// File: rtl/roi_tile_pooler.sv
// Streaming block-reduction pooler: raster pixels -> OUT_SIZE x OUT_SIZE grid of 8-bit tile results.
// Writes land 1 cycle after each tile's last pixel; frame_ready holds the grid until frame_ack.
module roi_tile_pooler #(
  parameter int FRAME_W  = 640,
  parameter int FRAME_H  = 480,
  parameter int OUT_SIZE = 28,
  parameter int BLK_W    = 8,
  parameter int BLK_H    = 8,
  parameter int X0       = 208,
  parameter int Y0       = 128,
  parameter int PIX_W    = 8,
  parameter int THRESH   = 6144,
  localparam int ACC_W   = $clog2(BLK_W*BLK_H) + PIX_W,
  localparam int AW      = $clog2(OUT_SIZE*OUT_SIZE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_valid,
  input  logic             pix_sof,
  input  logic [PIX_W-1:0] pix_data,
  input  logic             arm,
  input  logic [1:0]       mode,
  input  logic             frame_ack,
  output logic             wr_en,
  output logic [AW-1:0]    wr_addr,
  output logic [7:0]       wr_data,
  output logic             frame_ready,
  output logic             busy,
  output logic [7:0]       drop_cnt
);
  localparam int XW    = $clog2(FRAME_W+1);
  localparam int YW    = $clog2(FRAME_H+1);
  localparam int TW    = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
  localparam int LOG_N = $clog2(BLK_W*BLK_H);

  localparam logic [XW-1:0] X_LO  = XW'(X0);
  localparam logic [XW-1:0] X_HI  = XW'(X0 + OUT_SIZE*BLK_W);
  localparam logic [YW-1:0] Y_LO  = YW'(Y0);
  localparam logic [YW-1:0] Y_HI  = YW'(Y0 + OUT_SIZE*BLK_H);
  localparam logic [XW-1:0] X_MAX = XW'(FRAME_W-1);
  localparam logic [YW-1:0] Y_MAX = YW'(FRAME_H-1);
  localparam logic [XW-1:0] BW    = XW'(BLK_W);
  localparam logic [YW-1:0] BH    = YW'(BLK_H);
  localparam logic [TW-1:0] T_LAST = TW'(OUT_SIZE-1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_ACCUM = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  logic [1:0]       state, state_nx;
  logic [XW-1:0]    x_q, cur_x, rel_x;
  logic [YW-1:0]    y_q, cur_y, rel_y;
  logic [1:0]       mode_q, mode_eff;
  logic [ACC_W-1:0] acc [OUT_SIZE];
  logic [ACC_W-1:0] pix_ext, sum;
  logic [TW-1:0]    tx, ty;
  logic [7:0]       value;
  logic             start, active, in_roi, first_px, last_px, tile_done, last_tile, drop_ev;

  always_comb begin
    cur_x    = pix_sof ? '0 : x_q;
    cur_y    = pix_sof ? '0 : y_q;
    rel_x    = cur_x - X_LO;
    rel_y    = cur_y - Y_LO;
    in_roi   = (cur_x >= X_LO) && (cur_x < X_HI) && (cur_y >= Y_LO) && (cur_y < Y_HI);
    tx       = TW'(rel_x / BW);
    ty       = TW'(rel_y / BH);
    first_px = ((rel_x % BW) == '0) && ((rel_y % BH) == '0);
    last_px  = ((rel_x % BW) == BW - 1'b1) && ((rel_y % BH) == BH - 1'b1);
    pix_ext  = ACC_W'(pix_data);
    sum      = acc[tx] + pix_ext;

    // A sof in WAIT_SOF starts a frame; in ACCUM it restarts the truncated one.
    start     = pix_valid && pix_sof && (state == S_WAIT || state == S_ACCUM);
    active    = pix_valid && (state == S_ACCUM || start);
    mode_eff  = start ? mode : mode_q;
    tile_done = active && in_roi && last_px;
    last_tile = tile_done && (tx == T_LAST) && (ty == T_LAST);
    drop_ev   = pix_valid && pix_sof && (state == S_ACCUM || state == S_HOLD);

    if (mode_eff[0]) value = (sum >= ACC_W'(THRESH)) ? 8'hFF : 8'h00;
    else             value = 8'(sum >> LOG_N);
    if (mode_eff[1]) value = ~value;

    state_nx = state;
    case (state)
      S_IDLE:  if (arm) state_nx = S_WAIT;
      S_WAIT:  if (start) state_nx = S_ACCUM;
      S_ACCUM: if (last_tile) state_nx = S_HOLD;
      default: if (frame_ack) state_nx = arm ? S_WAIT : S_IDLE;
    endcase
  end

  assign busy = (state == S_ACCUM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      mode_q      <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      frame_ready <= 1'b0;
      drop_cnt    <= '0;
      for (int i = 0; i < OUT_SIZE; i++) acc[i] <= '0;
    end else begin
      state       <= state_nx;
      frame_ready <= (state == S_HOLD) && !frame_ack;
      wr_en       <= tile_done;
      if (start) mode_q <= mode;
      if (drop_ev && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;

      if (pix_valid) begin
        if (cur_x == X_MAX) begin
          x_q <= '0;
          y_q <= (cur_y == Y_MAX) ? '0 : cur_y + 1'b1;
        end else begin
          x_q <= cur_x + 1'b1;
          y_q <= cur_y;
        end
      end

      // The first pixel of a tile overwrites the stale sum, so the bank never needs clearing.
      if (active && in_roi) acc[tx] <= first_px ? pix_ext : sum;

      if (tile_done) begin
        wr_addr <= AW'(ty * OUT_SIZE + tx);
        wr_data <= value;
      end
    end
  end
endmodule

// File: tb/tb_roi_tile_pooler.sv
// Directed bench for roi_tile_pooler on an 8x8 frame with a 2x2 grid of 2x2 tiles at (2,2).
module tb_roi_tile_pooler;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pix_valid = 1'b0, pix_sof = 1'b0, arm = 1'b0, frame_ack = 1'b0;
  logic [7:0] pix_data = '0;
  logic [1:0] mode = '0;
  logic       wr_en, frame_ready, busy;
  logic [1:0] wr_addr;
  logic [7:0] wr_data, drop_cnt;

  roi_tile_pooler #(
    .FRAME_W(8), .FRAME_H(8), .OUT_SIZE(2), .BLK_W(2), .BLK_H(2),
    .X0(2), .Y0(2), .PIX_W(8), .THRESH(300)
  ) dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_data(pix_data),
    .arm(arm), .mode(mode), .frame_ack(frame_ack), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .frame_ready(frame_ready), .busy(busy), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0, wr_cnt = 0, last_wr_cyc = -1, fr_rise_cyc = -1, px55_cyc = -1;
  logic [7:0] mem [4];
  logic fr_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en) begin
      mem[wr_addr] = wr_data;
      wr_cnt++;
      last_wr_cyc = cyc;
    end
    if (frame_ready && !fr_prev) fr_rise_cyc = cyc;
    fr_prev = frame_ready;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic clear_log();
    wr_cnt = 0; fr_rise_cyc = -1; last_wr_cyc = -1; px55_cyc = -1;
    for (int a = 0; a < 4; a++) mem[a] = 8'h5A;
  endtask

  // kind 0: constant val; kind 1: horizontal gradient x*10. Sends the first npix pixels.
  task automatic send_frame(input int kind, input int val, input int npix);
    int n = 0;
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++) begin
        if (n < npix) begin
          @(negedge clk);
          pix_valid = 1'b1;
          pix_sof   = (x == 0 && y == 0);
          pix_data  = (kind == 0) ? 8'(val) : 8'(x * 10);
          if (x == 5 && y == 5) px55_cyc = cyc;
          n++;
        end
      end
    @(negedge clk);
    pix_valid = 1'b0; pix_sof = 1'b0;
  endtask

  task automatic do_ack();
    frame_ack = 1'b1;
    @(negedge clk);
    frame_ack = 1'b0;
    chk("ready_after_ack", int'(frame_ready), 0);
  endtask

  task automatic check_grid(input string tag, input int e0, input int e1, input int e2, input int e3);
    int e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    chk({tag, " wr_cnt"}, wr_cnt, 4);
    for (int a = 0; a < 4; a++) chk($sformatf("%s data[%0d]", tag, a), int'(mem[a]), e[a]);
  endtask

  typedef struct {
    int kind; int val; logic [1:0] md;
    int e0; int e1; int e2; int e3;
  } vec_t;
  vec_t vecs [7];

  initial begin
    vecs[0] = '{0, 100, 2'd0, 100, 100, 100, 100};
    vecs[1] = '{1,   0, 2'd0,  25,  45,  25,  45};
    vecs[2] = '{1,   0, 2'd2, 230, 210, 230, 210};
    vecs[3] = '{0, 100, 2'd1, 255, 255, 255, 255};
    vecs[4] = '{0,  50, 2'd1,   0,   0,   0,   0};
    vecs[5] = '{0,  75, 2'd1, 255, 255, 255, 255};
    vecs[6] = '{0, 100, 2'd3,   0,   0,   0,   0};

    idle(2);
    chk("rst wr_en", int'(wr_en), 0);
    chk("rst frame_ready", int'(frame_ready), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst drop_cnt", int'(drop_cnt), 0);
    chk("rst wr_addr", int'(wr_addr), 0);
    chk("rst wr_data", int'(wr_data), 0);
    rst = 1'b0;
    arm = 1'b1;
    idle(2);

    for (int i = 0; i < 7; i++) begin
      mode = vecs[i].md;
      clear_log();
      send_frame(vecs[i].kind, vecs[i].val, 64);
      idle(2);
      check_grid($sformatf("vec%0d", i), vecs[i].e0, vecs[i].e1, vecs[i].e2, vecs[i].e3);
      chk($sformatf("vec%0d last_wr_lat", i), last_wr_cyc - px55_cyc, 1);
      chk($sformatf("vec%0d ready_lat", i), fr_rise_cyc - px55_cyc, 2);
      chk($sformatf("vec%0d ready", i), int'(frame_ready), 1);
      do_ack();
    end
    chk("drop after vectors", int'(drop_cnt), 0);

    // Truncated frame: sof again after 20 pixels, then a full frame.
    mode = 2'd0;
    clear_log();
    send_frame(0, 100, 20);
    send_frame(0, 60, 64);
    idle(2);
    chk("trunc drop_cnt", int'(drop_cnt), 1);
    check_grid("trunc", 60, 60, 60, 60);
    chk("trunc ready", int'(frame_ready), 1);
    do_ack();

    // Second frame while holding is dropped; ack with arm low returns to idle.
    clear_log();
    send_frame(0, 100, 64);
    send_frame(0, 50, 64);
    idle(2);
    check_grid("hold", 100, 100, 100, 100);
    chk("hold drop_cnt", int'(drop_cnt), 2);
    chk("hold ready", int'(frame_ready), 1);
    arm = 1'b0;
    do_ack();
    chk("idle busy", int'(busy), 0);
    clear_log();
    send_frame(0, 100, 64);
    idle(2);
    chk("idle wr_cnt", wr_cnt, 0);
    chk("idle drop_cnt", int'(drop_cnt), 2);
    chk("idle ready", int'(frame_ready), 0);

    // Asynchronous reset in the middle of a frame.
    arm = 1'b1;
    idle(2);
    clear_log();
    send_frame(0, 100, 40);
    chk("midframe wr_cnt", wr_cnt, 2);
    chk("midframe busy", int'(busy), 1);
    #2 rst = 1'b1;
    #1;
    chk("async wr_addr", int'(wr_addr), 0);
    chk("async wr_data", int'(wr_data), 0);
    chk("async busy", int'(busy), 0);
    chk("async drop_cnt", int'(drop_cnt), 0);
    chk("async wr_en", int'(wr_en), 0);
    chk("async ready", int'(frame_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    idle(2);
    clear_log();
    send_frame(1, 0, 64);
    idle(2);
    check_grid("post_rst", 25, 45, 25, 45);
    chk("post_rst ready", int'(frame_ready), 1);
    chk("post_rst drop", int'(drop_cnt), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
